// File: rtl/cdce_readback_check_if.sv
// Serial link to the CDCE plus the expected-value ROM lookup used by the readback checker.
// The checker is the master: it drives chip select, command data and the ROM address.
interface cdce_readback_check_if;
  logic        cs_n;
  logic        mosi;
  logic        miso;
  logic [3:0]  rom_address;
  logic [31:0] expected_data;

  modport master (
    output cs_n,
    output mosi,
    output rom_address,
    input  miso,
    input  expected_data
  );

  modport slave (
    input  cs_n,
    input  mosi,
    input  rom_address,
    output miso,
    output expected_data
  );
endinterface

// File: rtl/cdce_readback_check.sv
// Post-configuration readback verifier: for each CDCE register it sends a read command,
// captures the 32-bit reply and compares it (masked) against the expected ROM word.
module cdce_readback_check #(
  parameter int unsigned NUM_REGS     = 9,
  parameter int unsigned GAP_CYCLES   = 4,
  parameter logic [31:0] COMPARE_MASK = 32'hFFFF_FFF0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  cdce_readback_check_if.master        bus,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [4:0]                   mismatch_count,
  output logic [3:0]                   first_fail
);

  localparam int unsigned      GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       LAST_ADDR = 4'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, CMD, GAP1, READ, COMPARE, GAP2, FINISH
  } state_t;

  state_t           state_q, state_d;
  logic             cs_n_q, cs_n_d;
  logic             mosi_q, mosi_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [4:0]       count_q, count_d;
  logic [3:0]       first_fail_q, first_fail_d;
  logic [3:0]       rom_address_q, rom_address_d;
  logic [31:0]      shift_q, shift_d;
  logic [31:0]      capture_q, capture_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [31:0]      cmd_word;
  logic             mismatch;

  always_comb begin
    state_d       = state_q;
    cs_n_d        = cs_n_q;
    mosi_d        = mosi_q;
    busy_d        = busy_q;
    done_d        = done_q;
    pass_d        = pass_q;
    count_d       = count_q;
    first_fail_d  = first_fail_q;
    rom_address_d = rom_address_q;
    shift_d       = shift_q;
    capture_d     = capture_q;
    bit_cnt_d     = bit_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    cmd_word      = {24'h0, rom_address_q, 4'hE};
    mismatch      = |((capture_q ^ bus.expected_data) & COMPARE_MASK);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          count_d       = 5'd0;
          first_fail_d  = 4'd0;
          done_d        = 1'b0;
          pass_d        = 1'b0;
          rom_address_d = 4'd0;
          busy_d        = 1'b1;
          state_d       = FETCH;
        end
      end

      // Outputs are registered, so bit 0 goes onto mosi as cs_n falls and the
      // shifter holds the remaining bits.
      FETCH: begin
        mosi_d    = cmd_word[0];
        shift_d   = cmd_word >> 1;
        cs_n_d    = 1'b0;
        bit_cnt_d = 5'd0;
        state_d   = CMD;
      end

      CMD: begin
        mosi_d    = shift_q[0];
        shift_d   = shift_q >> 1;
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q == 5'd31) begin
          cs_n_d    = 1'b1;
          mosi_d    = 1'b0;
          gap_cnt_d = '0;
          state_d   = GAP1;
        end
      end

      GAP1: begin
        gap_cnt_d = gap_cnt_q + 1'b1;
        if (gap_cnt_q == GAP_LAST) begin
          cs_n_d    = 1'b0;
          bit_cnt_d = 5'd0;
          state_d   = READ;
        end
      end

      READ: begin
        capture_d[bit_cnt_q] = bus.miso;
        bit_cnt_d            = bit_cnt_q + 5'd1;
        if (bit_cnt_q == 5'd31) begin
          cs_n_d  = 1'b1;
          state_d = COMPARE;
        end
      end

      // Status outputs for the pass are published on entry to FINISH.
      COMPARE: begin
        if (mismatch) begin
          count_d = count_q + 5'd1;
          if (count_q == 5'd0) begin
            first_fail_d = rom_address_q;
          end
        end
        if (rom_address_q == LAST_ADDR) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (count_d == 5'd0);
          state_d = FINISH;
        end else begin
          rom_address_d = rom_address_q + 4'd1;
          gap_cnt_d     = '0;
          state_d       = GAP2;
        end
      end

      GAP2: begin
        gap_cnt_d = gap_cnt_q + 1'b1;
        if (gap_cnt_q == GAP_LAST) begin
          state_d = FETCH;
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cs_n_q        <= 1'b1;
      mosi_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      count_q       <= 5'd0;
      first_fail_q  <= 4'd0;
      rom_address_q <= 4'd0;
      shift_q       <= 32'h0;
      capture_q     <= 32'h0;
      bit_cnt_q     <= 5'd0;
      gap_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      cs_n_q        <= cs_n_d;
      mosi_q        <= mosi_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      count_q       <= count_d;
      first_fail_q  <= first_fail_d;
      rom_address_q <= rom_address_d;
      shift_q       <= shift_d;
      capture_q     <= capture_d;
      bit_cnt_q     <= bit_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
    end
  end

  assign bus.cs_n        = cs_n_q;
  assign bus.mosi        = mosi_q;
  assign bus.rom_address = rom_address_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign mismatch_count  = count_q;
  assign first_fail      = first_fail_q;

endmodule
